// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Definitions shared by the ALU result collector and its FIFO.
//   SRC_W      : width of the source tag attached to every queued result
//   src_e      : source tag values (arith, logic, cmp, shift)
//   NUM_UNITS  : number of execution units feeding the collector
//   multi_hot  : true when two or more bits of a flag vector are set
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int SRC_W     = 2;
  localparam int NUM_UNITS = 4;

  typedef enum logic [SRC_W-1:0] {
    SRC_ARITH = 2'd0,
    SRC_LOGIC = 2'd1,
    SRC_CMP   = 2'd2,
    SRC_SHIFT = 2'd3
  } src_e;

  // Clearing the lowest set bit leaves something behind only if more than
  // one bit was set.
  function automatic logic multi_hot(input logic [NUM_UNITS-1:0] f);
    logic [NUM_UNITS-1:0] low_cleared;
    low_cleared = f & (f - 1'b1);
    return (low_cleared != '0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Show-ahead synchronous FIFO with a registered head output.
//   clk_i    : clock, rising edge
//   rst_ni   : asynchronous active-low reset (pointers, count, head, valid)
//   push_i   : write request; ignored when full unless a pop happens too
//   wdata_i  : write data
//   pop_i    : read request; only honoured while valid_o is high
//   rdata_o  : head entry (holds last value while empty)
//   valid_o  : FIFO non-empty, registered
//   full_o   : count_o == DEPTH
//   empty_o  : count_o == 0
//   count_o  : occupancy, $clog2(DEPTH)+1 bits
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    count_after_pop;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, valid_d;

  logic full;
  logic pop_fire;
  logic push_fire;

  assign full      = (count_q == CW'(DEPTH));
  assign pop_fire  = pop_i & valid_q;
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign push_fire = push_i & (~full | pop_fire);

  always_comb begin
    wr_ptr_d        = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d        = pop_fire  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_after_pop = count_q - {{(CW-1){1'b0}}, pop_fire};
    count_d         = count_after_pop + {{(CW-1){1'b0}}, push_fire};
    valid_d         = (count_d != '0);

    // The head register is loaded with whatever entry will sit at the
    // read pointer after this edge. If nothing older survives the pop,
    // that entry is the one being written right now, so bypass storage.
    head_d = head_q;
    if (count_d != '0) begin
      if (count_after_pop == '0) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  // Storage carries no reset; its contents are meaningless until written.
  always_ff @(posedge clk_i) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign full_o  = full;
  assign empty_o = ~valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Collects results from the four ALU execution units, tags each with its
// source, queues it in a show-ahead FIFO and presents it on a valid/ready
// port. Collisions and overflows are recorded as sticky error bits.
//   CLK, RST            : clock (rising edge) and async active-low reset
//   <UNIT>_OUT/_Flag    : unit result and its valid strobe
//                         (ARITH, LOGIC, CMP, SHIFT; priority in that order)
//   ERR_CLR             : clear both sticky error bits (a new event wins)
//   OUT_READY           : consumer accepts the head entry this cycle
//   OUT_DATA, OUT_SRC   : head entry result and source tag
//   OUT_VALID           : FIFO non-empty
//   COUNT               : FIFO occupancy
//   OVF_ERR             : a result was dropped because the FIFO was full
//   COL_ERR             : several unit flags were high in one cycle
// -----------------------------------------------------------------------------
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [WIDTH-1:0]       ARITH_OUT,
  input  logic                   ARITH_Flag,
  input  logic [WIDTH-1:0]       LOGIC_OUT,
  input  logic                   LOGIC_Flag,
  input  logic [WIDTH-1:0]       CMP_OUT,
  input  logic                   CMP_Flag,
  input  logic [WIDTH-1:0]       SHIFT_OUT,
  input  logic                   SHIFT_Flag,
  input  logic                   ERR_CLR,
  input  logic                   OUT_READY,
  output logic [WIDTH-1:0]       OUT_DATA,
  output logic [1:0]             OUT_SRC,
  output logic                   OUT_VALID,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVF_ERR,
  output logic                   COL_ERR
);

  localparam int EW = WIDTH + SRC_W;

  logic [NUM_UNITS-1:0] flags;
  logic                 push_req;
  logic                 col_event;
  logic                 ovf_event;
  src_e                 sel_src;
  logic [WIDTH-1:0]     sel_data;

  logic [EW-1:0]        fifo_wdata;
  logic [EW-1:0]        fifo_rdata;
  logic                 fifo_valid;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic ovf_q, ovf_d;
  logic col_q, col_d;

  assign flags     = {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag};
  assign push_req  = |flags;
  assign col_event = multi_hot(flags);

  // Fixed priority: lower-numbered units win; the losers are discarded.
  always_comb begin
    sel_src  = SRC_SHIFT;
    sel_data = SHIFT_OUT;
    if (ARITH_Flag) begin
      sel_src  = SRC_ARITH;
      sel_data = ARITH_OUT;
    end else if (LOGIC_Flag) begin
      sel_src  = SRC_LOGIC;
      sel_data = LOGIC_OUT;
    end else if (CMP_Flag) begin
      sel_src  = SRC_CMP;
      sel_data = CMP_OUT;
    end
  end

  assign fifo_wdata = {sel_src, sel_data};

  // Only a push into a full FIFO with no simultaneous pop loses data.
  assign ovf_event = push_req & fifo_full & ~(OUT_READY & ~fifo_empty);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .push_i  (push_req),
    .wdata_i (fifo_wdata),
    .pop_i   (OUT_READY),
    .rdata_o (fifo_rdata),
    .valid_o (fifo_valid),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Clear first, then OR in new events so a same-edge event survives.
  always_comb begin
    ovf_d = (ovf_q & ~ERR_CLR) | ovf_event;
    col_d = (col_q & ~ERR_CLR) | col_event;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ovf_q <= 1'b0;
      col_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      col_q <= col_d;
    end
  end

  assign OUT_DATA  = fifo_rdata[WIDTH-1:0];
  assign OUT_SRC   = fifo_rdata[EW-1:WIDTH];
  assign OUT_VALID = fifo_valid;
  assign COUNT     = fifo_count;
  assign OVF_ERR   = ovf_q;
  assign COL_ERR   = col_q;

endmodule
